// File: rtl/nn_mem_pkg.sv
// Shared types and default geometry for the neural-net memory loader.
package nn_mem_pkg;

  // Default geometry of mem_sys as seen by the loader.
  localparam int DEF_W_ADDR_LEN = 20;
  localparam int DEF_X_ADDR_LEN = 10;
  localparam int DEF_DATA_LEN   = 1;
  localparam int DEF_W_SEL_LEN  = 2;
  localparam int DEF_X_SEL_LEN  = 2;
  localparam int DEF_W_DEPTH    = 300;
  localparam int DEF_X_DEPTH    = 8;

  // Number of weight banks addressed by a W_SEL_LEN-bit select.
  function automatic int num_w_banks(input int sel_len);
    return 2 ** sel_len;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Loader FSM encoding; also visible on the state_dbg port.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_LOAD_X = 2'd2,
    ST_FIN    = 2'd3
  } state_t;

endpackage

// File: rtl/nn_bank_picker.sv
// Finds the next weight bank to load: the lowest set bit of mask that lies
// above cur, or the lowest set bit anywhere when from_zero is high.
module nn_bank_picker
  import nn_mem_pkg::*;
#(
  parameter int W_SEL_LEN = DEF_W_SEL_LEN
) (
  input  logic [2**W_SEL_LEN-1:0] mask,
  input  logic [W_SEL_LEN-1:0]    cur,
  input  logic                    from_zero,
  output logic [W_SEL_LEN-1:0]    bank,
  output logic                    none_left
);

  localparam int NUM = 2 ** W_SEL_LEN;

  logic [NUM-1:0] elig;

  // Qualify candidate banks, then pick the lowest qualified index.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM; i++) begin
      elig[i] = mask[i] & (from_zero | (i > int'(cur)));
    end
    bank = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (elig[i]) bank = W_SEL_LEN'(i);
    end
  end

  assign none_left = ~|elig;

endmodule

// File: rtl/nn_mem_loader.sv
// Streams weight and input words from a valid/ready source into the
// mem_sys write ports. Weight banks selected by w_mask are filled in
// ascending order, then one input bank is filled, then done pulses.
//
// Handshake: a word transfers (a "beat") on a rising edge where in_valid
// and in_ready are both high. in_ready depends only on the FSM state, never
// on in_valid. Each beat produces exactly one registered write on the
// following cycle; a beat in the same cycle as an accepted abort is dropped.
module nn_mem_loader
  import nn_mem_pkg::*;
#(
  parameter int W_ADDR_LEN = DEF_W_ADDR_LEN,
  parameter int X_ADDR_LEN = DEF_X_ADDR_LEN,
  parameter int DATA_LEN   = DEF_DATA_LEN,
  parameter int W_SEL_LEN  = DEF_W_SEL_LEN,
  parameter int X_SEL_LEN  = DEF_X_SEL_LEN,
  parameter int W_DEPTH    = DEF_W_DEPTH,
  parameter int X_DEPTH    = DEF_X_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2**W_SEL_LEN-1:0] w_mask,
  input  logic [X_SEL_LEN-1:0]    x_bank,
  input  logic                    abort,
  input  logic                    in_valid,
  input  logic [DATA_LEN-1:0]     in_data,
  output logic                    in_ready,
  output logic                    w_wq,
  output logic [W_SEL_LEN-1:0]    w_sel,
  output logic [W_ADDR_LEN-1:0]   w_addr,
  output logic                    x_wq,
  output logic [X_SEL_LEN-1:0]    x_sel,
  output logic [X_ADDR_LEN-1:0]   x_addr,
  output logic [DATA_LEN-1:0]     wx_write,
  output logic                    load_ctrl,
  output logic                    done,
  output logic                    aborted,
  output logic [1:0]              state_dbg
);

  localparam int NUM_W_BANKS = num_w_banks(W_SEL_LEN);
  localparam int CNT_LEN     = max_int(W_ADDR_LEN, X_ADDR_LEN);
  localparam logic [CNT_LEN-1:0] W_LAST = CNT_LEN'(W_DEPTH - 1);
  localparam logic [CNT_LEN-1:0] X_LAST = CNT_LEN'(X_DEPTH - 1);

  state_t                  state_q, state_d;
  logic [CNT_LEN-1:0]      cnt_q;
  logic [W_SEL_LEN-1:0]    bank_q;
  logic [NUM_W_BANKS-1:0]  mask_q;
  logic [X_SEL_LEN-1:0]    x_bank_q;

  logic                    beat;
  logic                    w_last;
  logic                    x_last;
  logic [NUM_W_BANKS-1:0]  pick_mask;
  logic                    pick_from_zero;
  logic [W_SEL_LEN-1:0]    pick_bank;
  logic                    pick_none;

  assign beat   = in_valid & in_ready;
  assign w_last = (cnt_q == W_LAST);
  assign x_last = (cnt_q == X_LAST);

  // In IDLE look at the fresh request for the first bank; while loading,
  // search the remaining mask above the bank being written.
  always_comb begin
    if (state_q == ST_IDLE) begin
      pick_mask      = w_mask;
      pick_from_zero = 1'b1;
    end else begin
      pick_mask      = mask_q;
      pick_from_zero = 1'b0;
    end
  end

  nn_bank_picker #(
    .W_SEL_LEN (W_SEL_LEN)
  ) u_bank_picker (
    .mask      (pick_mask),
    .cur       (bank_q),
    .from_zero (pick_from_zero),
    .bank      (pick_bank),
    .none_left (pick_none)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state logic; abort overrides progress in every busy state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = pick_none ? ST_LOAD_X : ST_LOAD_W;
      end
      ST_LOAD_W: begin
        if (abort)                            state_d = ST_IDLE;
        else if (beat && w_last && pick_none) state_d = ST_LOAD_X;
      end
      ST_LOAD_X: begin
        if (abort)                 state_d = ST_IDLE;
        else if (beat && x_last)   state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    in_ready  = (state_q == ST_LOAD_W) || (state_q == ST_LOAD_X);
    load_ctrl = (state_q != ST_IDLE);
    done      = (state_q == ST_FIN);
    state_dbg = state_q;
  end

  // Datapath: request capture, address counter, bank walk and registered
  // write port. Select/address/data hold between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      bank_q   <= '0;
      mask_q   <= '0;
      x_bank_q <= '0;
      w_wq     <= 1'b0;
      w_sel    <= '0;
      w_addr   <= '0;
      x_wq     <= 1'b0;
      x_sel    <= '0;
      x_addr   <= '0;
      wx_write <= '0;
      aborted  <= 1'b0;
    end else begin
      w_wq    <= 1'b0;
      x_wq    <= 1'b0;
      aborted <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (start) begin
          mask_q   <= w_mask;
          x_bank_q <= x_bank;
          bank_q   <= pick_bank;
          cnt_q    <= '0;
        end
      end else if (abort) begin
        cnt_q   <= '0;
        mask_q  <= '0;
        aborted <= 1'b1;
      end else if (beat) begin
        wx_write <= in_data;
        if (state_q == ST_LOAD_W) begin
          w_wq   <= 1'b1;
          w_sel  <= bank_q;
          w_addr <= cnt_q[W_ADDR_LEN-1:0];
          if (w_last) begin
            cnt_q          <= '0;
            mask_q[bank_q] <= 1'b0;
            if (!pick_none) bank_q <= pick_bank;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          x_wq   <= 1'b1;
          x_sel  <= x_bank_q;
          x_addr <= cnt_q[X_ADDR_LEN-1:0];
          if (x_last) cnt_q <= '0;
          else        cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nn_mem_loader.sv
// Directed bench for nn_mem_loader at default geometry
// (4 weight banks x 300 words, 8 input words, 1-bit data).
module tb_nn_mem_loader;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  w_mask = '0;
  logic [1:0]  x_bank = '0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [0:0]  in_data = '0;
  logic        in_ready;
  logic        w_wq;
  logic [1:0]  w_sel;
  logic [19:0] w_addr;
  logic        x_wq;
  logic [1:0]  x_sel;
  logic [9:0]  x_addr;
  logic [0:0]  wx_write;
  logic        load_ctrl;
  logic        done;
  logic        aborted;
  logic [1:0]  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start_cyc = 0;
  int done_at = 0;
  int n_done  = 0;
  int n_w     = 0;
  int n_x     = 0;
  int lc_low  = 0;
  logic in_load = 1'b0;
  string phase = "reset";

  logic [31:0] exp_q[$];

  nn_mem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .w_mask    (w_mask),
    .x_bank    (x_bank),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .w_wq      (w_wq),
    .w_sel     (w_sel),
    .w_addr    (w_addr),
    .x_wq      (x_wq),
    .x_sel     (x_sel),
    .x_addr    (x_addr),
    .wx_write  (wx_write),
    .load_ctrl (load_ctrl),
    .done      (done),
    .aborted   (aborted),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", phase, tag, got, exp);
    end
  endtask

  // Source stream: word k carries bit0 ^ bit3 of k.
  function automatic logic src_bit(input int k);
    logic [31:0] kv;
    kv = k;
    return kv[0] ^ kv[3];
  endfunction

  function automatic logic [31:0] pack(input logic is_x, input logic [1:0] sel,
                                       input logic [19:0] addr, input logic d);
    return {8'd0, is_x, sel, addr, d};
  endfunction

  task automatic push_w(input int bank, input int first_k, input int nwords);
    for (int i = 0; i < nwords; i++)
      exp_q.push_back(pack(1'b0, 2'(bank), 20'(i), src_bit(first_k + i)));
  endtask

  task automatic push_x(input int xb, input int first_k);
    for (int i = 0; i < 8; i++)
      exp_q.push_back(pack(1'b1, 2'(xb), 20'(i), src_bit(first_k + i)));
  endtask

  // Scoreboard monitor: every write must match the head of exp_q.
  always @(negedge clk) begin
    if (w_wq && x_wq) check("wq_exclusive", 32'd1, 32'd0);
    if (w_wq) begin
      n_w++;
      if (exp_q.size() == 0) check("extra_w_write", 32'd1, 32'd0);
      else check("w_write", pack(1'b0, w_sel, w_addr, wx_write[0]), exp_q.pop_front());
    end
    if (x_wq) begin
      n_x++;
      if (exp_q.size() == 0) check("extra_x_write", 32'd1, 32'd0);
      else check("x_write", pack(1'b1, x_sel, {10'd0, x_addr}, wx_write[0]), exp_q.pop_front());
    end
    if (done) begin
      n_done++;
      done_at = cyc;
    end
    if (in_load && !load_ctrl) lc_low++;
  end

  // ---------------- driver tasks ----------------
  task automatic start_load(input logic [3:0] mask, input logic [1:0] xb, input logic with_abort);
    @(negedge clk); #1;
    start = 1'b1; w_mask = mask; x_bank = xb; abort = with_abort;
    start_cyc = cyc;
    @(negedge clk); #1;
    start = 1'b0; abort = 1'b0; w_mask = '0; x_bank = '0;
    check("load_ctrl_set", 32'(load_ctrl), 32'd1);
    check("no_abort_pulse", 32'(aborted), 32'd0);
    in_load = 1'b1;
    lc_low = 0;
  endtask

  // vmode 0: in_valid always high; vmode 1: valid pattern 1,0,0 repeating.
  task automatic stream(input int vmode, input int abort_at, input int budget);
    int k;
    int t;
    int d0;
    k = 0; t = 0; d0 = n_done;
    while (n_done == d0 && t < budget) begin
      if (abort_at >= 0 && k == abort_at) begin
        in_valid = 1'b1; in_data = src_bit(k); abort = 1'b1;
        @(negedge clk); #1;
        abort = 1'b0;
        check("abort_pulse", 32'(aborted), 32'd1);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_state", 32'(state_dbg), 32'd0);
        check("abort_load_ctrl", 32'(load_ctrl), 32'd0);
        in_load = 1'b0;
        return;
      end
      in_valid = (vmode == 0) ? 1'b1 : (t % 3 == 0);
      in_data  = src_bit(k);
      if (in_valid && in_ready) k++;
      @(negedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    check("done_seen", 32'(n_done - d0), 32'd1);
  endtask

  task automatic end_checks(input int exp_lat);
    in_valid = 1'b0;
    in_load  = 1'b0;
    if (exp_lat > 0) check("done_latency", 32'(done_at - start_cyc), 32'(exp_lat));
    check("load_ctrl_hold", 32'(lc_low), 32'd0);
    @(negedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_state", 32'(state_dbg), 32'd0);
    check("idle_load_ctrl", 32'(load_ctrl), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int w0;
    int x0;
    int d0;

    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_w_wq", 32'(w_wq), 32'd0);
    check("rst_x_wq", 32'(x_wq), 32'd0);
    check("rst_load_ctrl", 32'(load_ctrl), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Full load of all four banks, then input bank 0.
    phase = "full";
    w0 = n_w; x0 = n_x;
    push_w(0, 0, 300); push_w(1, 300, 300); push_w(2, 600, 300); push_w(3, 900, 300);
    push_x(0, 1200);
    start_load(4'b1111, 2'd0, 1'b0);
    stream(0, -1, 1400);
    end_checks(1209);
    check("w_count", 32'(n_w - w0), 32'd1200);
    check("x_count", 32'(n_x - x0), 32'd8);

    // Sparse mask: banks 0 and 2 only.
    phase = "sparse";
    push_w(0, 0, 300); push_w(2, 300, 300); push_x(1, 600);
    start_load(4'b0101, 2'd1, 1'b0);
    stream(0, -1, 800);
    end_checks(609);

    // Input-only reload into bank 2.
    phase = "x_only";
    w0 = n_w; x0 = n_x;
    push_x(2, 0);
    start_load(4'b0000, 2'd2, 1'b0);
    stream(0, -1, 40);
    end_checks(9);
    check("x_only_no_w", 32'(n_w - w0), 32'd0);
    check("x_only_x_count", 32'(n_x - x0), 32'd8);

    // Backpressure on bank 1 plus input bank 3.
    phase = "backpressure";
    push_w(1, 0, 300); push_x(3, 300);
    start_load(4'b0010, 2'd3, 1'b0);
    stream(1, -1, 1500);
    end_checks(0);

    // Abort at beat 150 of bank 1 (global beat 450).
    phase = "abort";
    d0 = n_done; w0 = n_w;
    push_w(0, 0, 300); push_w(1, 300, 150);
    start_load(4'b0011, 2'd0, 1'b0);
    stream(0, 450, 1000);
    in_valid = 1'b1;
    @(negedge clk); #1;
    check("abort_pulse_width", 32'(aborted), 32'd0);
    repeat (10) @(negedge clk);
    #1;
    check("abort_no_writes", 32'(n_w - w0), 32'd450);
    check("abort_no_done", 32'(n_done - d0), 32'd0);
    check("abort_exp_drained", 32'(exp_q.size()), 32'd0);
    in_valid = 1'b0;

    // Abort while idle is ignored.
    abort = 1'b1;
    @(negedge clk); #1;
    abort = 1'b0;
    check("idle_abort_no_pulse", 32'(aborted), 32'd0);
    check("idle_abort_state", 32'(state_dbg), 32'd0);

    // Restart with start and abort together: start wins, addresses from 0.
    phase = "restart";
    push_w(1, 0, 300); push_x(1, 300);
    start_load(4'b0010, 2'd1, 1'b1);
    stream(0, -1, 400);
    end_checks(309);

    // Asynchronous reset mid input load with the clock stopped.
    phase = "async_rst";
    push_x(3, 0);
    start_load(4'b0000, 2'd3, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = src_bit(i);
      @(negedge clk); #1;
    end
    clk_en = 1'b0;
    check("pre_rst_x_wq", 32'(x_wq), 32'd1);
    check("pre_rst_x_addr", 32'(x_addr), 32'd2);
    check("pre_rst_state", 32'(state_dbg), 32'd2);
    #1 rst = 1'b0;
    #1;
    check("async_x_wq", 32'(x_wq), 32'd0);
    check("async_x_sel", 32'(x_sel), 32'd0);
    check("async_x_addr", 32'(x_addr), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd0);
    check("async_load_ctrl", 32'(load_ctrl), 32'd0);
    check("async_state", 32'(state_dbg), 32'd0);
    exp_q.delete();
    in_valid = 1'b0;
    in_load  = 1'b0;
    #10 rst = 1'b1;
    #4 clk_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("post_rst_idle", 32'(state_dbg), 32'd0);
    check("post_rst_no_write", 32'(x_wq), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
